// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t        : converter FSM encoding (IDLE / SHIFT / DONE)
//   pow10()        : constant function, 10^n, used to derive MAX_VAL
//   BLANK_RST_ALL  : reset blank pattern (all digits blanked except digit 0);
//                    the top slices the low DIGITS bits.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [63:0] BLANK_RST_ALL = ~64'd1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq.
//   in_valid/in_ready/bin_in          : operand request side
//   out_valid/out_ready               : result handshake
//   bcd_out/blank/ovf                 : held display result
// master = producer/consumer of the converter, slave = the converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, blank, ovf
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, blank, ovf
  );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration, purely combinational.
//   acc_i : current BCD accumulator (4*DIGITS bits)
//   msb_i : next binary bit entering at the bottom
//   acc_o : accumulator after per-nibble add-3 correction and a left shift
module bcd_dabble_step #(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] acc_i,
  input  logic                msb_i,
  output logic [4*DIGITS-1:0] acc_o
);

  logic [4*DIGITS-1:0] corr;
  // The corrected top bit always falls off the accumulator; the upstream
  // saturation keeps it zero.
  logic                unused_top;

  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_digit
    // 4-bit add: the carry is intentionally confined to the nibble.
    assign corr[4*i +: 4] = (acc_i[4*i +: 4] >= 4'd5) ? acc_i[4*i +: 4] + 4'd3
                                                       : acc_i[4*i +: 4];
  end

  assign acc_o      = {corr[4*DIGITS-2:0], msb_i};
  assign unused_top = corr[4*DIGITS-1];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter for the HEX displays.
//   CLOCK_50 : system clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bin_to_bcd_seq_if
//                in_valid/in_ready/bin_in  accept one operand in IDLE
//                out_valid/out_ready       result handshake, held in DONE
//                bcd_out                   packed BCD, digit i in [4i+3:4i]
//                blank                     leading-zero mask (bit 0 never set)
//                ovf                       input exceeded 10^DIGITS-1, saturated
// Inputs above MAX_VAL are clamped so the accumulator never overflows its top
// digit. Results stay on the outputs after the handshake so displays hold.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int                 ACC_W     = 4 * DIGITS;
  localparam int                 CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0]        MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [BIN_W-1:0]   MAX_SAT   = BIN_W'(MAX_VAL);
  localparam logic [DIGITS-1:0]  BLANK_RST = BLANK_RST_ALL[DIGITS-1:0];

  state_t              state_q,    state_d;
  logic [BIN_W-1:0]    operand_q,  operand_d;
  logic [ACC_W-1:0]    acc_q,      acc_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [ACC_W-1:0]    bcd_q,      bcd_d;
  logic [DIGITS-1:0]   blank_q,    blank_d;
  logic                ovf_q,      ovf_d;

  logic [ACC_W-1:0]    step_acc;
  logic                over;

  // Digit i (i >= 1) is blanked when it and every higher digit are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [ACC_W-1:0] acc);
    logic [DIGITS-1:0] b;
    logic              hi_zero;
    b       = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (acc[4*i +: 4] == 4'd0);
      b[i]    = hi_zero;
    end
    return b;
  endfunction

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .acc_i (acc_q),
    .msb_i (operand_q[BIN_W-1]),
    .acc_o (step_acc)
  );

  assign over = (64'(bus.bin_in) > MAX_VAL);

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          operand_d  = over ? MAX_SAT : bus.bin_in;
          ovf_pend_d = over;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d     = step_acc;
        operand_d = operand_q << 1;
        cnt_d     = cnt_q - CNT_W'(1);
        // Last iteration: publish the finished accumulator on this edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = step_acc;
          ovf_d   = ovf_pend_q;
          blank_d = blank_of(step_acc);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.blank     = blank_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq at default parameters (BIN_W=20, DIGITS=6).
module tb_bin_to_bcd_seq;

  logic CLOCK_50 = 1'b0;
  logic reset_n;

  always #10 CLOCK_50 = ~CLOCK_50;

  bin_to_bcd_seq_if #(.BIN_W(20), .DIGITS(6)) bus ();

  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: decimal arithmetic on the saturated value.
  function automatic int unsigned sat_of(input int unsigned v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned s;
    logic [23:0] r;
    s = sat_of(v);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_blank(input int unsigned v);
    int unsigned s;
    int unsigned p;
    logic [5:0] b;
    s = sat_of(v);
    b = '0;
    p = 1;
    for (int i = 1; i < 6; i++) begin
      p = p * 10;
      b[i] = (s < p);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_bcd_out"},   bus.bcd_out,   0);
    chk({tag, "_ovf"},       bus.ovf,       0);
    chk({tag, "_blank"},     bus.blank,     6'b111110);
  endtask

  task automatic accept(input logic [19:0] v);
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    bus.in_valid = 1'b0;
    bus.bin_in   = 20'($urandom);
    chk("busy_after_accept", bus.in_ready, 0);
  endtask

  // Counts cycles from the acceptance edge until out_valid, scrambling the
  // inputs meanwhile, then checks the result against the model.
  task automatic wait_result(input int unsigned v);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge CLOCK_50); #1;
      n++;
      if (bus.out_valid) break;
      bus.bin_in   = 20'($urandom);
      bus.in_valid = 1'($urandom);
    end
    chk("latency",       n,             20);
    chk("bcd_out",       bus.bcd_out,   ref_bcd(v));
    chk("blank",         bus.blank,     ref_blank(v));
    chk("ovf",           bus.ovf,       (v > 999999) ? 1 : 0);
    chk("in_ready_done", bus.in_ready,  0);
  endtask

  task automatic release_out(input int unsigned v);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge CLOCK_50); #1;
    bus.out_ready = 1'b0;
    chk("rel_out_valid", bus.out_valid, 0);
    chk("rel_in_ready",  bus.in_ready,  1);
    chk("rel_bcd_hold",  bus.bcd_out,   ref_bcd(v));
    chk("rel_blank_hold", bus.blank,    ref_blank(v));
  endtask

  task automatic convert(input int unsigned v);
    accept(20'(v));
    wait_result(v);
    release_out(v);
  endtask

  initial begin
    int unsigned v;
    int unsigned v2;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("idle_after_rst", bus.in_ready, 1);

    // Directed values from the plan, including saturation boundaries.
    convert(123456);
    convert(7);
    convert(0);
    convert(1048575);
    convert(999999);
    convert(1000000);

    // Backpressure: result held for 15 cycles while inputs churn.
    v = 31415;
    accept(20'(v));
    wait_result(v);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'($urandom);
      bus.bin_in   = 20'($urandom);
      @(posedge CLOCK_50); #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready",  bus.in_ready,  0);
      chk("bp_bcd",       bus.bcd_out,   ref_bcd(v));
    end
    v2 = 271828;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bin_in    = 20'(v2);
    @(posedge CLOCK_50); #1;
    bus.out_ready = 1'b0;
    chk("bp_rel_out_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready",  bus.in_ready,  1);
    @(posedge CLOCK_50); #1;
    bus.in_valid = 1'b0;
    chk("bp_next_accepted", bus.in_ready, 0);
    wait_result(v2);
    release_out(v2);

    // Reset in the middle of a conversion.
    accept(20'(654321));
    repeat (10) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("midrst_idle", bus.in_ready, 1);
    convert(100);

    // Randomized values, a third of them around or above saturation.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) v = $urandom_range(1048575, 999990);
      else            v = $urandom_range(1048575, 0);
      convert(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
